// File: rtl/pipelined_compressor_tree.sv
// Pipelined carry-save compressor tree: NUM_ELEMENTS terms reduced by
// 6:3 / 3:2 levels to a (C, S) pair, with a register every LEVELS_PER_STAGE
// levels, a global-stall valid/ready handshake and an optional final adder.
module pipelined_compressor_tree #(
  parameter int NUM_ELEMENTS     = 9,
  parameter int BIT_LEN          = 16,
  parameter int LEVELS_PER_STAGE = 1,
  parameter int FINAL_ADD        = 0,
  parameter int TAG_W            = 8
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [TAG_W-1:0]   in_tag,
  input  logic [BIT_LEN-1:0] terms [NUM_ELEMENTS],
  output logic               out_valid,
  input  logic               out_ready,
  output logic [TAG_W-1:0]   out_tag,
  output logic [BIT_LEN-1:0] C,
  output logic [BIT_LEN-1:0] S,
  output logic [BIT_LEN-1:0] sum
);

  // Term count after one compressor level.
  function automatic int next_cnt(input int n);
    int r;
    if (n <= 2) return n;
    r = n % 6;
    return 3 * (n / 6) + ((r >= 4) ? 3 : (r == 3) ? 2 : r);
  endfunction

  function automatic int cnt_at(input int lvl);
    int n = NUM_ELEMENTS;
    for (int i = 0; i < lvl; i++) n = next_cnt(n);
    return n;
  endfunction

  function automatic int num_levels(input int n0);
    int n = n0;
    int d = 0;
    while (n > 2) begin
      n = next_cnt(n);
      d++;
    end
    return d;
  endfunction

  // 6:3 compressor: per-bit population count split into weight 1/2/4 vectors.
  function automatic logic [3*BIT_LEN-1:0] comp63(
    input logic [BIT_LEN-1:0] a, b, c, d, e, f);
    logic [BIT_LEN-1:0] w1, w2, w4;
    logic [2:0]         k;
    for (int i = 0; i < BIT_LEN; i++) begin
      k = 3'(a[i]) + 3'(b[i]) + 3'(c[i]) + 3'(d[i]) + 3'(e[i]) + 3'(f[i]);
      w1[i] = k[0];
      w2[i] = k[1];
      w4[i] = k[2];
    end
    return {w4 << 2, w2 << 1, w1};
  endfunction

  // 3:2 carry-save adder: {carry shifted left with MSB carry dropped, sum}.
  function automatic logic [2*BIT_LEN-1:0] csa32(
    input logic [BIT_LEN-1:0] a, b, c);
    return {((a & b) | (a & c) | (b & c)) << 1, a ^ b ^ c};
  endfunction

  localparam int D      = num_levels(NUM_ELEMENTS);
  localparam int STAGES = (D == 0) ? 1 : (D + LEVELS_PER_STAGE - 1) / LEVELS_PER_STAGE;
  localparam int NF     = cnt_at(D);

  logic en;
  assign en       = out_ready | ~out_valid;
  assign in_ready = en;

  for (genvar l = 0; l < D; l++) begin : g_lvl
    localparam int NI = cnt_at(l);
    localparam int NO = cnt_at(l + 1);
    localparam int G  = NI / 6;
    localparam int R  = NI % 6;
    logic [BIT_LEN-1:0] x [NI];
    logic [BIT_LEN-1:0] y [NO];

    if (l == 0) begin : g_src
      assign x = terms;
    end else if (l % LEVELS_PER_STAGE == 0) begin : g_src
      assign x = g_mid[l / LEVELS_PER_STAGE - 1].data_p;
    end else begin : g_src
      assign x = g_lvl[l - 1].y;
    end

    for (genvar g = 0; g < G; g++) begin : g_c63
      assign {y[3*g+2], y[3*g+1], y[3*g]} =
        comp63(x[6*g], x[6*g+1], x[6*g+2], x[6*g+3], x[6*g+4], x[6*g+5]);
    end

    if (R == 5) begin : g_rem
      assign {y[3*G+2], y[3*G+1], y[3*G]} =
        comp63(x[6*G], x[6*G+1], x[6*G+2], x[6*G+3], x[6*G+4], '0);
    end else if (R == 4) begin : g_rem
      assign {y[3*G+2], y[3*G+1], y[3*G]} =
        comp63(x[6*G], x[6*G+1], x[6*G+2], x[6*G+3], '0, '0);
    end else if (R == 3) begin : g_rem
      assign {y[3*G+1], y[3*G]} = csa32(x[6*G], x[6*G+1], x[6*G+2]);
    end else if (R == 2) begin : g_rem
      assign y[3*G]   = x[6*G];
      assign y[3*G+1] = x[6*G+1];
    end else if (R == 1) begin : g_rem
      assign y[3*G] = x[6*G];
    end
  end

  // ---- intermediate stage registers (every LEVELS_PER_STAGE levels) ----
  for (genvar s = 0; s < STAGES - 1; s++) begin : g_mid
    localparam int LV = (s + 1) * LEVELS_PER_STAGE - 1;
    localparam int NQ = cnt_at(LV + 1);
    logic [BIT_LEN-1:0] data_p [NQ];
    logic               vld_p;
    logic [TAG_W-1:0]   tag_p;
    logic               vld_in;
    logic [TAG_W-1:0]   tag_in;

    if (s == 0) begin : g_in
      assign vld_in = in_valid;
      assign tag_in = in_tag;
    end else begin : g_in
      assign vld_in = g_mid[s - 1].vld_p;
      assign tag_in = g_mid[s - 1].tag_p;
    end

    // Stage valid bit advances with the global enable, cleared by reset.
    always_ff @(posedge clk or negedge rst_n)
      if (!rst_n)  vld_p <= 1'b0;
      else if (en) vld_p <= vld_in;

    // Stage data and tag load whenever the pipeline moves; bubbles carry junk.
    always_ff @(posedge clk)
      if (en) begin
        data_p <= g_lvl[LV].y;
        tag_p  <= tag_in;
      end
  end

  // ---- carry-save output stage ----
  logic [BIT_LEN-1:0] fin [NF];
  logic               fin_vld;
  logic [TAG_W-1:0]   fin_tag;
  logic [BIT_LEN-1:0] c_nxt;

  if (D == 0) begin : g_fin
    assign fin = terms;
  end else begin : g_fin
    assign fin = g_lvl[D - 1].y;
  end

  if (STAGES == 1) begin : g_fin_ctl
    assign fin_vld = in_valid;
    assign fin_tag = in_tag;
  end else begin : g_fin_ctl
    assign fin_vld = g_mid[STAGES - 2].vld_p;
    assign fin_tag = g_mid[STAGES - 2].tag_p;
  end

  if (NF == 1) begin : g_cnxt
    assign c_nxt = '0;
  end else begin : g_cnxt
    assign c_nxt = fin[1];
  end

  logic               vld_p0;
  logic [BIT_LEN-1:0] c_p0, s_p0;
  logic [TAG_W-1:0]   tag_p0;

  // Last tree stage always registers C, S and the tag; outputs reset to 0.
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      vld_p0 <= 1'b0;
      c_p0   <= '0;
      s_p0   <= '0;
      tag_p0 <= '0;
    end else if (en) begin
      vld_p0 <= fin_vld;
      c_p0   <= c_nxt;
      s_p0   <= fin[0];
      tag_p0 <= fin_tag;
    end

  // ---- optional carry-propagate stage ----
  if (FINAL_ADD != 0) begin : g_add
    logic               vld_p1;
    logic [BIT_LEN-1:0] c_p1, s_p1, sum_p1;
    logic [TAG_W-1:0]   tag_p1;

    // Resolve C + S, keeping C, S and tag aligned with the sum.
    always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) begin
        vld_p1 <= 1'b0;
        c_p1   <= '0;
        s_p1   <= '0;
        sum_p1 <= '0;
        tag_p1 <= '0;
      end else if (en) begin
        vld_p1 <= vld_p0;
        c_p1   <= c_p0;
        s_p1   <= s_p0;
        sum_p1 <= c_p0 + s_p0;
        tag_p1 <= tag_p0;
      end

    assign out_valid = vld_p1;
    assign out_tag   = tag_p1;
    assign C         = c_p1;
    assign S         = s_p1;
    assign sum       = sum_p1;
  end else begin : g_noadd
    assign out_valid = vld_p0;
    assign out_tag   = tag_p0;
    assign C         = c_p0;
    assign S         = s_p0;
    assign sum       = '0;
  end

endmodule

// File: tb/tb_pipelined_compressor_tree.sv
// Bench for pipelined_compressor_tree: five configurations (N=9 with and
// without final add, N=16 with two levels per stage, N=1, N=2).
module tb_pipelined_compressor_tree;
  localparam int W  = 16;
  localparam int TW = 8;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  int n_vec = 0;
  int n_bad = 0;

  // N=9 pair (shared inputs, separate out_ready)
  logic          v9, r9, r9f;
  logic [TW-1:0] tag9;
  logic [W-1:0]  t9 [9];
  logic          ir9, ov9, ir9f, ov9f;
  logic [TW-1:0] otag9, otag9f;
  logic [W-1:0]  c9, s9, sum9, c9f, s9f, sum9f;

  // N=16, LPS=2
  logic          v16, r16;
  logic [TW-1:0] tag16;
  logic [W-1:0]  t16 [16];
  logic          ir16, ov16;
  logic [TW-1:0] otag16;
  logic [W-1:0]  c16, s16, sum16;

  // N=1 and N=2
  logic          v1, r1, v2, r2;
  logic [TW-1:0] tag1, tag2;
  logic [W-1:0]  t1 [1];
  logic [W-1:0]  t2 [2];
  logic          ir1, ov1, ir2, ov2;
  logic [TW-1:0] otag1, otag2;
  logic [W-1:0]  c1, s1, sum1, c2, s2, sum2;

  pipelined_compressor_tree #(.NUM_ELEMENTS(9), .BIT_LEN(W), .LEVELS_PER_STAGE(1),
    .FINAL_ADD(0), .TAG_W(TW)) u9 (
    .clk(clk), .rst_n(rst_n), .in_valid(v9), .in_ready(ir9), .in_tag(tag9), .terms(t9),
    .out_valid(ov9), .out_ready(r9), .out_tag(otag9), .C(c9), .S(s9), .sum(sum9));

  pipelined_compressor_tree #(.NUM_ELEMENTS(9), .BIT_LEN(W), .LEVELS_PER_STAGE(1),
    .FINAL_ADD(1), .TAG_W(TW)) u9f (
    .clk(clk), .rst_n(rst_n), .in_valid(v9), .in_ready(ir9f), .in_tag(tag9), .terms(t9),
    .out_valid(ov9f), .out_ready(r9f), .out_tag(otag9f), .C(c9f), .S(s9f), .sum(sum9f));

  pipelined_compressor_tree #(.NUM_ELEMENTS(16), .BIT_LEN(W), .LEVELS_PER_STAGE(2),
    .FINAL_ADD(0), .TAG_W(TW)) u16 (
    .clk(clk), .rst_n(rst_n), .in_valid(v16), .in_ready(ir16), .in_tag(tag16), .terms(t16),
    .out_valid(ov16), .out_ready(r16), .out_tag(otag16), .C(c16), .S(s16), .sum(sum16));

  pipelined_compressor_tree #(.NUM_ELEMENTS(1), .BIT_LEN(W), .LEVELS_PER_STAGE(1),
    .FINAL_ADD(0), .TAG_W(TW)) u1 (
    .clk(clk), .rst_n(rst_n), .in_valid(v1), .in_ready(ir1), .in_tag(tag1), .terms(t1),
    .out_valid(ov1), .out_ready(r1), .out_tag(otag1), .C(c1), .S(s1), .sum(sum1));

  pipelined_compressor_tree #(.NUM_ELEMENTS(2), .BIT_LEN(W), .LEVELS_PER_STAGE(1),
    .FINAL_ADD(0), .TAG_W(TW)) u2 (
    .clk(clk), .rst_n(rst_n), .in_valid(v2), .in_ready(ir2), .in_tag(tag2), .terms(t2),
    .out_valid(ov2), .out_ready(r2), .out_tag(otag2), .C(c2), .S(s2), .sum(sum2));

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  typedef struct packed {
    logic [8:0][W-1:0] t;
    logic [TW-1:0]     tag;
    logic [W-1:0]      exp;
  } vec9_t;

  typedef struct {
    logic [TW-1:0] tag;
    logic [W-1:0]  sum;
    int            acc;
  } exp_t;

  vec9_t         tbl [6];
  exp_t          q [$];
  exp_t          e;
  int            lat, stale, nxt_tag, acc;
  logic [W-1:0]  sc, ss;
  logic [TW-1:0] stag;

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    v9 = 0; r9 = 1; r9f = 1; tag9 = '0;
    v16 = 0; r16 = 1; tag16 = '0;
    v1 = 0; r1 = 1; tag1 = '0; v2 = 0; r2 = 1; tag2 = '0;
    for (int i = 0; i < 9; i++) t9[i] = '0;
    for (int i = 0; i < 16; i++) t16[i] = '0;
    t1[0] = '0; t2[0] = '0; t2[1] = '0;

    // Vector table: N=9 terms, tag, expected sum of terms mod 2^16
    tbl[0].t = {9{16'hFFFF}}; tbl[0].tag = 8'h5A; tbl[0].exp = 16'hFFF7;
    for (int i = 0; i < 9; i++) tbl[1].t[i] = 16'(i + 1);
    tbl[1].tag = 8'h2D; tbl[1].exp = 16'h002D;
    tbl[2].t = {9{16'h8000}}; tbl[2].tag = 8'h01; tbl[2].exp = 16'h8000;
    tbl[3].t = {9{16'h1111}}; tbl[3].tag = 8'hC3; tbl[3].exp = 16'h9999;
    tbl[4].t = '0; tbl[4].t[0] = 16'hFFFF; tbl[4].t[8] = 16'h0001;
    tbl[4].tag = 8'hFF; tbl[4].exp = 16'h0000;
    for (int i = 0; i < 9; i++) tbl[5].t[i] = 16'(1 << i);
    tbl[5].tag = 8'h00; tbl[5].exp = 16'h01FF;

    // Reset state
    repeat (3) @(posedge clk);
    #1;
    chk("reset u9 out_valid", ov9, 0);
    chk("reset u9 C", c9, 0);
    chk("reset u9 S", s9, 0);
    chk("reset u9 out_tag", otag9, 0);
    chk("reset u9f sum", sum9f, 0);
    chk("reset u16 out_valid", ov16, 0);
    #1 rst_n = 1'b1;
    tick();
    chk("in_ready after reset", ir9, 1);

    // Table: u9 result at latency 3, u9f at latency 4
    for (int k = 0; k < 6; k++) begin
      for (int i = 0; i < 9; i++) t9[i] = tbl[k].t[i];
      tag9 = tbl[k].tag;
      v9 = 1; tick(); v9 = 0;
      tick();
      chk("u9 early valid", ov9, 0);
      tick();
      chk("u9 valid at latency 3", ov9, 1);
      chk("u9 C+S", 16'(c9 + s9), tbl[k].exp);
      chk("u9 tag", otag9, tbl[k].tag);
      chk("u9 sum tied 0", sum9, 0);
      chk("u9f not yet valid", ov9f, 0);
      tick();
      chk("u9 single delivery", ov9, 0);
      chk("u9f valid at latency 4", ov9f, 1);
      chk("u9f sum", sum9f, tbl[k].exp);
      chk("u9f C+S", 16'(c9f + s9f), tbl[k].exp);
      chk("u9f tag", otag9f, tbl[k].tag);
      tick();
    end

    // FINAL_ADD: terms 1..9 held at output while out_ready is low
    for (int i = 0; i < 9; i++) t9[i] = 16'(i + 1);
    tag9 = 8'h33; r9f = 0;
    v9 = 1; tick(); v9 = 0;
    repeat (3) tick();
    chk("hold u9f valid", ov9f, 1);
    chk("hold u9f sum", sum9f, 16'h002D);
    chk("hold u9f tag", otag9f, 8'h33);
    for (int h = 0; h < 3; h++) begin
      tick();
      chk("hold u9f stays valid", ov9f, 1);
      chk("hold u9f sum stable", sum9f, 16'h002D);
      chk("hold u9f tag stable", otag9f, 8'h33);
      chk("hold u9f in_ready low", ir9f, 0);
    end
    r9f = 1;
    tick();
    chk("hold u9f released", ov9f, 0);
    tick();

    // N=1 and N=2 degenerate trees: latency 1
    t1[0] = 16'h1234; tag1 = 8'h11;
    t2[0] = 16'h1234; t2[1] = 16'h0001; tag2 = 8'h22;
    v1 = 1; v2 = 1; tick(); v1 = 0; v2 = 0;
    chk("u1 valid", ov1, 1);
    chk("u1 S", s1, 16'h1234);
    chk("u1 C", c1, 16'h0000);
    chk("u1 tag", otag1, 8'h11);
    chk("u2 valid", ov2, 1);
    chk("u2 S", s2, 16'h1234);
    chk("u2 C", c2, 16'h0001);
    chk("u2 tag", otag2, 8'h22);
    tick();
    chk("u1 single delivery", ov1, 0);
    chk("u2 single delivery", ov2, 0);

    // N=16 stream: 100 beats, stall window, then random valid/ready
    nxt_tag = 0;
    for (int cy = 0; cy < 400 && (nxt_tag < 100 || q.size() > 0); cy++) begin
      if (cy < 45) r16 = 1;
      else if (cy < 50) r16 = 0;
      else r16 = ($urandom_range(0, 3) != 0);
      if (nxt_tag < 100) begin
        v16 = (cy < 50) ? 1'b1 : ($urandom_range(0, 4) != 0);
        tag16 = 8'(nxt_tag);
        for (int i = 0; i < 16; i++) t16[i] = 16'($urandom);
      end else begin
        v16 = 0;
      end
      @(negedge clk);
      if (cy >= 45 && cy < 50) begin
        chk("stall in_ready low", ir16, 0);
        chk("stall out_valid", ov16, 1);
        if (cy == 45) begin
          sc = c16; ss = s16; stag = otag16;
        end else begin
          chk("stall C stable", c16, sc);
          chk("stall S stable", s16, ss);
          chk("stall tag stable", otag16, stag);
        end
      end
      if (ov16 && r16) begin
        if (q.size() == 0) begin
          chk("u16 unexpected beat", 1, 0);
        end else begin
          e = q.pop_front();
          chk("u16 tag order", otag16, e.tag);
          chk("u16 C+S", 16'(c16 + s16), e.sum);
          if (cy < 45) chk("u16 latency", cy - e.acc, 2);
        end
      end
      if (v16 && ir16) begin
        acc = 0;
        for (int i = 0; i < 16; i++) acc += int'(t16[i]);
        e.tag = tag16; e.sum = 16'(acc); e.acc = cy;
        q.push_back(e);
        nxt_tag++;
      end
      @(posedge clk);
      #1;
    end
    v16 = 0; r16 = 1;
    chk("u16 all beats accepted", nxt_tag, 100);
    chk("u16 all beats delivered", q.size(), 0);
    chk("u16 sum tied 0", sum16, 0);

    // Reset with three beats in flight
    tick();
    for (int b = 1; b <= 3; b++) begin
      for (int i = 0; i < 9; i++) t9[i] = 16'h1111;
      tag9 = 8'(b);
      v9 = 1; tick();
    end
    v9 = 0;
    chk("pre-reset u9 valid", ov9, 1);
    chk("pre-reset u9 tag", otag9, 1);
    chk("pre-reset u9 C+S", 16'(c9 + s9), 16'h9999);
    rst_n = 1'b0;
    #1;
    chk("async reset u9 valid", ov9, 0);
    chk("async reset u9 C", c9, 0);
    chk("async reset u9 S", s9, 0);
    chk("async reset u9 tag", otag9, 0);
    chk("async reset u9f valid", ov9f, 0);
    chk("async reset u9f sum", sum9f, 0);
    @(negedge clk);
    rst_n = 1'b1;
    stale = 0;
    for (int c = 0; c < 6; c++) begin
      tick();
      if (ov9 || ov9f) stale++;
    end
    chk("no stale beat after reset", stale, 0);
    chk("in_ready after reset release", ir9, 1);
    for (int i = 0; i < 9; i++) t9[i] = 16'h0002;
    tag9 = 8'h77;
    v9 = 1; tick(); v9 = 0;
    lat = 1;
    while (!ov9 && lat < 10) begin
      tick();
      lat++;
    end
    chk("post-reset latency", lat, 3);
    chk("post-reset C+S", 16'(c9 + s9), 16'h0012);
    chk("post-reset tag", otag9, 8'h77);
    repeat (3) tick();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
